// File: rtl/la_ioring_seq_if.sv
// Segment-mask load handshake for la_ioring_seq.
// A mask word transfers on a rising clk edge where cfg_valid and cfg_ready are both high.
// cfg_ready depends only on sequencer state; cfg_data is sampled only on that edge.
interface la_ioring_seq_if #(
    parameter int RINGW = 8
);
    logic             cfg_valid;
    logic [RINGW-1:0] cfg_data;
    logic             cfg_ready;

    modport master (
        output cfg_valid,
        output cfg_data,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_data,
        output cfg_ready
    );
endinterface

// File: rtl/la_ioring_seq.sv
// IO ring power sequencer: enables ring segments one bit per settle period, disables in reverse.
// Optional LA_IORING_FAULT_EN adds a fault input that drops the ring at once and latches fault_flag.
module la_ioring_seq #(
    parameter        PROP  = "DEFAULT",
    parameter int    RINGW = 8,
    parameter int    DLYW  = 8
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic             en,
    input  logic [DLYW-1:0]  settle,
    la_ioring_seq_if.slave   cfg,
    output logic [RINGW-1:0] ioring,
    output logic             busy,
    output logic             up,
`ifdef LA_IORING_FAULT_EN
    input  logic             fault,
    output logic             fault_flag,
`endif
    output logic [1:0]       dbg_state
);

    localparam logic [1:0] S_OFF  = 2'd0;
    localparam logic [1:0] S_RAMP = 2'd1;
    localparam logic [1:0] S_ON   = 2'd2;
    localparam logic [1:0] S_DOWN = 2'd3;

    localparam logic [DLYW-1:0]  ONE_D  = DLYW'(1);
    localparam logic [RINGW-1:0] ONE_R  = RINGW'(1);
    localparam logic [RINGW-1:0] ALL1_R = '1;

    logic [1:0]       state, state_d;
    logic [RINGW-1:0] therm, therm_d;
    logic [RINGW-1:0] mask, mask_d;
    logic [DLYW-1:0]  cnt, cnt_d;
    logic [DLYW-1:0]  n, n_d;
    logic [DLYW-1:0]  settle_n;
    logic [RINGW-1:0] therm_up, therm_dn;
    logic             step;
    logic             blocked;

`ifdef LA_IORING_FAULT_EN
    logic flag_d;
    assign blocked = fault_flag;
`else
    assign blocked = 1'b0;
`endif

    assign settle_n  = (settle == '0) ? ONE_D : settle;
    assign step      = (cnt == (n - ONE_D));
    assign therm_up  = (therm << 1) | ONE_R;
    assign therm_dn  = therm >> 1;
    assign cfg.cfg_ready = (state == S_OFF);
    assign dbg_state = state;

    always_comb begin
        state_d = state;
        therm_d = therm;
        mask_d  = mask;
        cnt_d   = cnt;
        n_d     = n;
`ifdef LA_IORING_FAULT_EN
        flag_d  = fault_flag;
`endif
        case (state)
            S_OFF: begin
                if (cfg.cfg_valid) mask_d = cfg.cfg_data;
                if (en && !blocked) begin
                    state_d = S_RAMP;
                    n_d     = settle_n;
                    cnt_d   = '0;
                end
            end
            S_RAMP: begin
                if (!en) begin
                    state_d = S_DOWN;
                    cnt_d   = '0;
                end else if (step) begin
                    therm_d = therm_up;
                    cnt_d   = '0;
                    if (therm_up == ALL1_R) state_d = S_ON;
                end else begin
                    cnt_d = cnt + ONE_D;
                end
            end
            S_ON: begin
                if (!en) begin
                    state_d = S_DOWN;
                    n_d     = settle_n;
                    cnt_d   = '0;
                end
            end
            default: begin
                if (en) begin
                    state_d = S_RAMP;
                    cnt_d   = '0;
                end else if (step) begin
                    therm_d = therm_dn;
                    cnt_d   = '0;
                    if (therm_dn == '0) state_d = S_OFF;
                end else begin
                    cnt_d = cnt + ONE_D;
                end
            end
        endcase
`ifdef LA_IORING_FAULT_EN
        // Fault wins over everything: ring drops in one edge, no ramp-down.
        if (fault) begin
            state_d = S_OFF;
            therm_d = '0;
            cnt_d   = '0;
            flag_d  = 1'b1;
        end else if (fault_flag && !en) begin
            flag_d  = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state  <= S_OFF;
            therm  <= '0;
            mask   <= '1;
            cnt    <= '0;
            n      <= ONE_D;
            ioring <= '0;
            busy   <= 1'b0;
            up     <= 1'b0;
`ifdef LA_IORING_FAULT_EN
            fault_flag <= 1'b0;
`endif
        end else begin
            state  <= state_d;
            therm  <= therm_d;
            mask   <= mask_d;
            cnt    <= cnt_d;
            n      <= n_d;
            ioring <= therm_d & mask_d;
            busy   <= (state_d == S_RAMP) || (state_d == S_DOWN);
            up     <= (state_d == S_ON);
`ifdef LA_IORING_FAULT_EN
            fault_flag <= flag_d;
`endif
        end
    end

endmodule
